mdu_hilo: RTL and testbench

Sequential multiply/divide unit that owns the architectural HI/LO registers and serves mult, multu, div and divu requests issued by the execute stage. It accepts one operation per start pulse. It computes iteratively, one bit per cycle, and writes HI/LO on completion with a done pulse. It sits beside the combinational ALU in the execute stage. The pipeline stalls on busy, and mfhi/mflo read hi/lo directly.

---
 rtl/mdu_hilo.sv | 206 ++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: sequential multiply/divide unit that owns the HI/LO registers.
//
// Serves mult, multu, div and divu. Operands are captured as magnitudes and
// the unit computes one bit per cycle: shift-add for multiply, restoring
// division for divide. A final fix-up cycle applies the result signs and
// writes HI/LO with a one-cycle done pulse.
//
// Optional build macro: MDU_FAST_MULT_EN
//   defined   : mult/multu form the full product in one cycle (IDLE -> FIX)
//   undefined : every operation uses the iterative path
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   start        request pulse, sampled only in IDLE
//   op           00 mult, 01 multu, 10 div, 11 divu
//   gr1, gr2     rs / rt operands
//   mthi, mtlo   write wdata to HI / LO, honoured only in IDLE without start
//   wdata        data for mthi / mtlo
//   busy         operation in progress (CALC or FIX)
//   done         one-cycle pulse when HI/LO take a new result
//   div_by_zero  last divide had a zero divisor; cleared by next start
//   hi, lo       architectural HI / LO
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo accepted here
// CALC  | one multiplier or quotient bit per cycle, WIDTH cycles
// FIX   | apply signs, write HI/LO, pulse done
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] gr1,
  input  logic [WIDTH-1:0] gr2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] raw_q, raw_d;       // raw dividend, returned on divide by zero
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             dbz_q, dbz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   rem_sh, div_diff;
  logic             qbit;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign signed_op = ~op[0];
  assign abs_a = (signed_op && gr1[WIDTH-1]) ? (~gr1 + WIDTH'(1)) : gr1;
  assign abs_b = (signed_op && gr2[WIDTH-1]) ? (~gr2 + WIDTH'(1)) : gr2;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  // The remainder stays below the divisor, so WIDTH+1 bits hold the trial.
  assign rem_sh   = acc_q[W2-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, opnd_q};
  assign qbit     = ~div_diff[WIDTH];
  assign div_next = {(qbit ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], qbit};

  assign prod_fix = neg_res_q ? (~acc_q + W2'(1)) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    raw_d      = raw_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_pend_d = dbz_pend_q;
    dbz_d      = dbz_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d   = op[1];
          raw_d      = gr1;
          opnd_d     = op[1] ? abs_b : abs_a;
          acc_d      = op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
          neg_res_d  = signed_op & (gr1[WIDTH-1] ^ gr2[WIDTH-1]);
          neg_rem_d  = signed_op & gr1[WIDTH-1];
          dbz_pend_d = op[1] & (gr2 == '0);
          dbz_d      = 1'b0;
          cnt_d      = '0;
          state_d    = S_CALC;
`ifdef MDU_FAST_MULT_EN
          if (!op[1]) begin
            acc_d   = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
            state_d = S_FIX;
          end
`endif
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end

      S_FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dbz_pend_q) begin
          hi_d = raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        dbz_d   = dbz_pend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_div_q   <= 1'b0;
      acc_q      <= '0;
      opnd_q     <= '0;
      raw_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      dbz_q      <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      raw_q      <= raw_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_pend_q <= dbz_pend_d;
      dbz_q      <= dbz_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: self-checking bench for mdu_hilo with a result scoreboard.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] gr1 = '0, gr2 = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  // Scoreboard entries: {div_by_zero, hi, lo}
  logic [64:0] sb_q[$];

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .gr1(gr1), .gr2(gr2),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] pu;
    case (o)
      2'b00: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa * sb;
        return {1'b0, 64'(q)};
      end
      2'b01: begin
        pu = 64'(a) * 64'(b);
        return {1'b0, pu};
      end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {1'b0, 32'(r), 32'(q)};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
    return o[1] ? 33 : 1;
`else
    return (o == 2'b00 || o != 2'b00) ? 33 : 33;
`endif
  endfunction

  // Drives one start pulse (caller's mthi/mtlo/wdata remain on for that edge),
  // then waits for done. Optionally injects start(div)+mtlo while busy.
  // Returns observations only; each test compares them itself.
  task automatic exec_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output int lat, output logic tmo,
                         output logic busy_bad, output logic dbz_early);
    op = o; gr1 = a; gr2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    dbz_early = div_by_zero;
    busy_bad = ~busy;
    lat = 0;
    tmo = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == inj) begin
        start = 1'b1; op = 2'b10; gr1 = 32'd100; gr2 = 32'd7;
        mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
      end else if (c == inj + 1) begin
        start = 1'b0; mtlo = 1'b0;
      end
      if (done) begin
        lat = c;
        tmo = 1'b0;
        break;
      end
      if (!busy) busy_bad = 1'b1;
    end
    start = 1'b0; mtlo = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h want all 0",
               busy, done, div_by_zero, hi, lo);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mt();
    mthi = 1'b1; wdata = 32'hAAAA_5555;
    @(posedge clk); #1; mthi = 1'b0;
    total++;
    if (hi !== 32'hAAAA_5555) begin
      bad++; $display("FAIL mthi: got hi=%h want AAAA5555", hi);
    end
    mtlo = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1; mtlo = 1'b0;
    total++;
    if ({hi, lo} !== {32'hAAAA_5555, 32'h0000_1234}) begin
      bad++; $display("FAIL mtlo: got hi=%h lo=%h want AAAA5555 00001234", hi, lo);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h5A5A_C3C3;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    total++;
    if ({hi, lo} !== {2{32'h5A5A_C3C3}}) begin
      bad++; $display("FAIL mt_both: got hi=%h lo=%h want 5A5AC3C3 x2", hi, lo);
    end
  endtask

  task automatic test_ops(input string name, input logic [1:0] ops[4],
                          input logic [31:0] as[4], input logic [31:0] bs[4], input int n);
    int lat; logic tmo, bb, de; logic [64:0] e;
    for (int i = 0; i < n; i++) begin
      sb_q.push_back(model(ops[i], as[i], bs[i]));
      exec_op(ops[i], as[i], bs[i], 0, lat, tmo, bb, de);
      e = sb_q.pop_front();
      total++;
      if (tmo || lat != exp_lat(ops[i]) || bb) begin
        bad++;
        $display("FAIL %s_latency[%0d]: got lat=%0d tmo=%b busy_gap=%b want lat=%0d",
                 name, i, lat, tmo, bb, exp_lat(ops[i]));
      end
      total++;
      if ({div_by_zero, hi, lo} !== e) begin
        bad++;
        $display("FAIL %s_result[%0d]: got dbz=%b hi=%h lo=%h want dbz=%b hi=%h lo=%h",
                 name, i, div_by_zero, hi, lo, e[64], e[63:32], e[31:0]);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL %s_done_pulse[%0d]: got done=%b busy=%b want 0 0",
                        name, i, done, busy);
      end
    end
  endtask

  task automatic test_mult();
    logic [1:0] o[4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic [31:0] a[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] b[4] = '{32'd3, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
    test_ops("mult", o, a, b, 4);
  endtask

  task automatic test_div();
    logic [1:0] o[4] = '{2'b10, 2'b11, 2'b10, 2'b10};
    logic [31:0] a[4] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7};
    logic [31:0] b[4] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    test_ops("div", o, a, b, 4);
  endtask

  task automatic test_div_by_zero();
    int lat; logic tmo, bb, de; logic [64:0] e;
    sb_q.push_back(model(2'b11, 32'h1234, 32'd0));
    exec_op(2'b11, 32'h1234, 32'd0, 0, lat, tmo, bb, de);
    e = sb_q.pop_front();
    total++;
    if (tmo || lat != 33 || {div_by_zero, hi, lo} !== e) begin
      bad++;
      $display("FAIL dbz_result: got lat=%0d dbz=%b hi=%h lo=%h want lat=33 dbz=%b hi=%h lo=%h",
               lat, div_by_zero, hi, lo, e[64], e[63:32], e[31:0]);
    end
    @(posedge clk); #1;
    total++;
    if (div_by_zero !== 1'b1) begin
      bad++; $display("FAIL dbz_sticky: got dbz=%b want 1", div_by_zero);
    end
    sb_q.push_back(model(2'b01, 32'd9, 32'd9));
    exec_op(2'b01, 32'd9, 32'd9, 0, lat, tmo, bb, de);
    e = sb_q.pop_front();
    total++;
    if (de !== 1'b0) begin
      bad++; $display("FAIL dbz_clear: got dbz=%b after next start want 0", de);
    end
    total++;
    if ({div_by_zero, hi, lo} !== e) begin
      bad++; $display("FAIL dbz_next_result: got hi=%h lo=%h want hi=%h lo=%h",
                      hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_busy_ignore();
    int lat; logic tmo, bb, de; logic [64:0] e;
    sb_q.push_back(model(2'b00, 32'd5, 32'd6));
    mthi = 1'b1; wdata = 32'hFFFF_0000;   // same cycle as start: must be dropped
    exec_op(2'b00, 32'd5, 32'd6, 5, lat, tmo, bb, de);
    e = sb_q.pop_front();
    total++;
    if (tmo || lat != exp_lat(2'b00)) begin
      bad++; $display("FAIL ignore_latency: got lat=%0d tmo=%b want %0d",
                      lat, tmo, exp_lat(2'b00));
    end
    total++;
    if ({div_by_zero, hi, lo} !== e) begin
      bad++; $display("FAIL ignore_result: got hi=%h lo=%h want hi=%h lo=%h",
                      hi, lo, e[63:32], e[31:0]);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) break;
    end
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL ignore_no_queue: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic tmo, bb, de; logic [64:0] e; logic saw;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h7777_1111;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; gr1 = 32'h1_0000; gr2 = 32'h1_0000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      bad++; $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h want 0",
                      busy, done, hi, lo);
    end
    #2 rst = 1'b0;
    saw = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) saw = 1'b1; end
    total++;
    if (saw !== 1'b0) begin
      bad++; $display("FAIL reset_no_done: got activity=%b want 0", saw);
    end
    sb_q.push_back(model(2'b00, 32'd2, 32'd3));
    exec_op(2'b00, 32'd2, 32'd3, 0, lat, tmo, bb, de);
    e = sb_q.pop_front();
    total++;
    if (tmo || {div_by_zero, hi, lo} !== e) begin
      bad++; $display("FAIL reset_recover: got tmo=%b hi=%h lo=%h want hi=%h lo=%h",
                      tmo, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic tmo, bb, de; logic [64:0] e;
    logic [1:0] o; logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom();
      b = (i % 5 == 3) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom());
      sb_q.push_back(model(o, a, b));
      exec_op(o, a, b, 0, lat, tmo, bb, de);
      e = sb_q.pop_front();
      total++;
      if (tmo || lat != exp_lat(o) || {div_by_zero, hi, lo} !== e) begin
        bad++;
        $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got lat=%0d dbz=%b hi=%h lo=%h want lat=%0d dbz=%b hi=%h lo=%h",
                 i, o, a, b, lat, div_by_zero, hi, lo, exp_lat(o), e[64], e[63:32], e[31:0]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_mt();
    test_mult();
    test_div();
    test_div_by_zero();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
